wavetable_voice_engine: RTL

WAVETABLE_VOICE_ENGINE -- requirements
Module: wavetable_voice_engine

---
 rtl/wavetable_pkg.sv | 29 ++
 rtl/sine_rom.sv | 39 +++
 rtl/wavetable_voice_engine.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/wavetable_pkg.sv
// Shared types and constants for the wavetable voice engine.
// Holds the FSM state type, the note-to-phase-increment table and the midscale helper.
package wavetable_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    INTERP,
    ACCUM,
    EMIT
  } state_t;

  // Entries 2..30 form a semitone ladder starting at 0x2000.
  // Entries 0, 1 and 31 are fixed ratios: one table step per frame, half a step, and all-ones.
  localparam logic [23:0] PHASE_INC [32] = '{
    24'h010000, 24'h008000,
    24'h002000, 24'h0021E7, 24'h0023EB, 24'h00260E, 24'h002851, 24'h002AB7,
    24'h002D41, 24'h002FF2, 24'h0032CC, 24'h0035D1, 24'h003904, 24'h003C68,
    24'h004000, 24'h0043CE, 24'h0047D6, 24'h004C1C, 24'h0050A2, 24'h00556E,
    24'h005A82, 24'h005FE4, 24'h006598, 24'h006BA2, 24'h007208, 24'h0078D0,
    24'h008000, 24'h00879C, 24'h008FAC, 24'h009838, 24'h00A145,
    24'hFFFFFF
  };

  function automatic int unsigned midscale(input int unsigned amp_w);
    return 32'd1 << (amp_w - 1);
  endfunction

endpackage

// File: rtl/sine_rom.sv
// Full-cycle offset-binary sine table with two synchronous read ports.
// Both ports register their data one cycle after the address is presented.
module sine_rom
  import wavetable_pkg::*;
#(
  parameter int AMP_W  = 8,
  parameter int TBL_AW = 8
) (
  input  logic              clk,
  input  logic [TBL_AW-1:0] addr_a,
  input  logic [TBL_AW-1:0] addr_b,
  output logic [AMP_W-1:0]  data_a,
  output logic [AMP_W-1:0]  data_b
);

  localparam int DEPTH = 1 << TBL_AW;
  localparam real PI = 3.14159265358979;

  // Peak amplitude is midscale-1 so the positive peak still fits in AMP_W bits.
  function automatic logic [AMP_W-1:0] sine_entry(input int idx);
    real mid;
    real val;
    mid = real'(midscale(AMP_W));
    val = mid + (mid - 1.0) * $sin(2.0 * PI * real'(idx) / real'(DEPTH)) + 0.5;
    return AMP_W'($rtoi(val));
  endfunction

  logic [AMP_W-1:0] tbl [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
    assign tbl[g] = sine_entry(g);
  end

  always_ff @(posedge clk) begin
    data_a <= tbl[addr_a];
    data_b <= tbl[addr_b];
  end

endmodule

// File: rtl/wavetable_voice_engine.sv
// Multi-voice wavetable oscillator: per frame, each voice is fetched, interpolated and
// mixed in turn, and the averaged result is offered on a valid/ready output.
//
//   state  | meaning
//   IDLE   | waiting for sample_tick; output frame may still be pending
//   FETCH  | present phase index and neighbour to the sine ROM
//   INTERP | linear interpolation between the two table samples
//   ACCUM  | add voice (or midscale if gated off) to the mix, advance phase
//   EMIT   | scale the mix into out_sample and raise out_valid
module wavetable_voice_engine
  import wavetable_pkg::*;
#(
  parameter int N_VOICES = 4,
  parameter int AMP_W    = 8,
  parameter int PHASE_W  = 24,
  parameter int TBL_AW   = 8
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             sample_tick,
  input  logic                                             cfg_we,
  input  logic [$clog2(N_VOICES > 1 ? N_VOICES : 2)-1:0]   cfg_voice,
  input  logic [4:0]                                       cfg_note,
  input  logic                                             cfg_on,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [AMP_W-1:0]                                 out_sample,
  output logic                                             overrun,
  output logic                                             busy
);

  localparam int VW     = $clog2(N_VOICES > 1 ? N_VOICES : 2);
  localparam int LOG2N  = $clog2(N_VOICES);
  localparam int FRAC_W = PHASE_W - TBL_AW;
  localparam int ACC_W  = AMP_W + LOG2N;
  localparam logic [AMP_W-1:0] MID = AMP_W'(midscale(AMP_W));

  state_t              state;
  logic [VW-1:0]       vcnt;
  logic [ACC_W-1:0]    acc;
  logic [FRAC_W-1:0]   frac_q;
  logic [AMP_W-1:0]    y_q;

  logic                gate  [N_VOICES];
  logic [4:0]          note  [N_VOICES];
  logic [PHASE_W-1:0]  phase [N_VOICES];

  logic [TBL_AW-1:0]   idx_a;
  logic [TBL_AW-1:0]   idx_b;
  logic [AMP_W-1:0]    rom_a;
  logic [AMP_W-1:0]    rom_b;

  assign idx_a = phase[vcnt][PHASE_W-1 -: TBL_AW];
  assign idx_b = idx_a + 1'b1;

  sine_rom #(
    .AMP_W  (AMP_W),
    .TBL_AW (TBL_AW)
  ) u_rom (
    .clk    (clk),
    .addr_a (idx_a),
    .addr_b (idx_b),
    .data_a (rom_a),
    .data_b (rom_b)
  );

  // Signed slope times unsigned fraction; the arithmetic shift floors, keeping y between a and b.
  logic signed [AMP_W:0]            diff;
  logic signed [AMP_W+FRAC_W+1:0]   prod;
  logic signed [AMP_W+1:0]          step;
  logic signed [AMP_W+1:0]          interp_sum;

  always_comb begin
    diff       = $signed({1'b0, rom_b}) - $signed({1'b0, rom_a});
    prod       = diff * $signed({1'b0, frac_q});
    step       = prod[FRAC_W +: AMP_W+2];
    interp_sum = $signed({2'b00, rom_a}) + step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vcnt       <= '0;
      acc        <= '0;
      frac_q     <= '0;
      y_q        <= '0;
      out_valid  <= 1'b0;
      out_sample <= MID;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            if (!out_valid || out_ready) begin
              state <= FETCH;
              vcnt  <= '0;
              acc   <= '0;
              busy  <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        FETCH: begin
          frac_q <= phase[vcnt][FRAC_W-1:0];
          state  <= INTERP;
        end
        INTERP: begin
          y_q   <= interp_sum[AMP_W-1:0];
          state <= ACCUM;
        end
        ACCUM: begin
          acc <= acc + ACC_W'(gate[vcnt] ? y_q : MID);
          if (vcnt == VW'(N_VOICES - 1)) begin
            state <= EMIT;
          end else begin
            vcnt  <= vcnt + 1'b1;
            state <= FETCH;
          end
        end
        EMIT: begin
          out_sample <= acc[ACC_W-1:LOG2N];
          out_valid  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A config write lands after the ACCUM update so a gate-on clear always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_VOICES; i++) begin
        gate[i]  <= 1'b0;
        note[i]  <= '0;
        phase[i] <= '0;
      end
    end else begin
      if (state == ACCUM && gate[vcnt])
        phase[vcnt] <= phase[vcnt] + PHASE_W'(PHASE_INC[note[vcnt]]);
      if (cfg_we) begin
        gate[cfg_voice] <= cfg_on;
        note[cfg_voice] <= cfg_note;
        if (cfg_on && !gate[cfg_voice]) phase[cfg_voice] <= '0;
      end
    end
  end

endmodule
